// File: rtl/linear_job_scheduler.sv
// linear_job_scheduler: shares one Linear matmul engine among NREQ requesters (round-robin).
// RUN-state watchdog is built only when LINSCHED_TIMEOUT_EN is defined; otherwise err stays 0.
//
// state | meaning
// IDLE  | no job in flight; arbitrate among pending requests
// START | owner granted, layer_sel settling; trigger is issued on exit
// RUN   | engine running (trigger high in first cycle); waiting for lin_finish
// DONE  | done pulse to owner; grant released on exit

module linear_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int OUT     = 16,
  parameter int TIMEOUT = 1023,
  parameter int SEL_W   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic                busy,
  output logic [SEL_W-1:0]    layer_sel,
  output logic                lin_trigger,
  input  logic                lin_finish,
  input  logic [OUT*16-1:0]   lin_out,
  output logic [OUT*16-1:0]   result
);

  localparam int RW = OUT * 16;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("linear_job_scheduler: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic              err_q;
  logic              busy_q;
  logic              trig_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  last_q;
  logic [RW-1:0]     result_q;
  logic [SEL_W-1:0]  pick_d;

`ifdef LINSCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  wdog_q;
`endif

  // Scan downward in priority so the nearest requester after last_owner wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] pick;
    int idx;
    pick = last;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NREQ;
      if (r[idx[SEL_W-1:0]]) pick = idx[SEL_W-1:0];
    end
    return pick;
  endfunction

  always_comb begin
    pick_d = rr_pick(req, last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      trig_q   <= 1'b0;
      sel_q    <= '0;
      last_q   <= SEL_W'(NREQ - 1);
      result_q <= '0;
`ifdef LINSCHED_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      trig_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            sel_q   <= pick_d;
            grant_q <= NREQ'(1) << pick_d;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          trig_q  <= 1'b1;
          state_q <= S_RUN;
`ifdef LINSCHED_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        S_RUN: begin
          // Finish takes priority over a watchdog expiry in the same cycle.
          if (lin_finish) begin
            result_q <= lin_out;
            done_q   <= grant_q;
            state_q  <= S_DONE;
          end
`ifdef LINSCHED_TIMEOUT_EN
          else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= grant_q;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          last_q  <= sel_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign layer_sel   = sel_q;
  assign lin_trigger = trig_q;
  assign result      = result_q;

endmodule

// File: tb/tb_linear_job_scheduler.sv
// Bench for linear_job_scheduler: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_linear_job_scheduler;

  localparam int NREQ  = 4;
  localparam int OUT   = 16;
  localparam int SEL_W = 2;
  localparam int RW    = OUT * 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic [SEL_W-1:0]  layer_sel;
  logic              lin_trigger;
  logic              lin_finish = 1'b0;
  logic [RW-1:0]     lin_out = '0;
  logic [RW-1:0]     result;

  linear_job_scheduler #(.NREQ(NREQ), .OUT(OUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .done(done), .err(err),
    .busy(busy), .layer_sel(layer_sel), .lin_trigger(lin_trigger),
    .lin_finish(lin_finish), .lin_out(lin_out), .result(result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Job-level reference model: one job record (owner, grant cycle, finish cycle).
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_owner = 0;
  int            m_last = NREQ - 1;
  int            m_t0 = 0;
  int            m_fin = -1;
  logic [RW-1:0] m_res = '0;

  function automatic int rr(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return last;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; m_owner = 0; m_last = NREQ - 1; m_fin = -1; m_res = '0;
    end else if (m_act) begin
      if (m_fin < 0) begin
        if (cyc >= m_t0 + 1 && lin_finish) begin
          m_fin = cyc;
          m_res = lin_out;
        end
      end else if (cyc == m_fin + 1) begin
        m_act  = 1'b0;
        m_last = m_owner;
      end
    end else if (req != '0) begin
      m_owner = rr(req, m_last);
      m_act   = 1'b1;
      m_t0    = cyc + 1;
      m_fin   = -1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << m_owner;
    if (!rst_n) begin
      chk("rst_grant", grant, '0);
      chk("rst_done", done, '0);
      chk("rst_busy", busy, '0);
      chk("rst_trig", lin_trigger, '0);
      chk("rst_sel", layer_sel, '0);
      chk("rst_result", result, '0);
      chk("rst_err", err, '0);
    end else begin
      chk("m_grant", grant, m_act ? oh : '0);
      chk("m_done", done, (m_act && m_fin >= 0) ? oh : '0);
      chk("m_busy", busy, m_act);
      chk("m_trig", lin_trigger, m_act && (cyc == m_t0 + 1));
      chk("m_sel", layer_sel, m_owner);
      chk("m_result", result, m_res);
      chk("m_err", err, 1'b0);
    end
  end

  // Engine and requester stimulus; all inputs change 2 time units after posedge.
  int            eng_cnt = 0;
  int            eng_lat = 5;
  logic [RW-1:0] eng_val = '0;
  bit            rnd_mode = 1'b0;

  function automatic logic [RW-1:0] rand_vec();
    logic [RW-1:0] v;
    for (int l = 0; l < OUT; l++) v[l*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    lin_finish = 1'b0;
    if (!rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          lin_finish = 1'b1;
          lin_out    = eng_val;
        end
      end
      if (lin_trigger) begin
        if (rnd_mode) begin
          eng_lat = $urandom_range(1, 8);
          eng_val = rand_vec();
        end
        eng_cnt = eng_lat;
      end
      if (rnd_mode) begin
        if (eng_cnt == 0 && !lin_finish && $urandom_range(0, 15) == 0) begin
          lin_finish = 1'b1;
          lin_out    = rand_vec();
        end
        req = req & ~done;
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && grant[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
          else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (done != '0) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  task automatic wait_grant(input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (grant != '0) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    int c_req, c_trig, c_done, nd, ntrig, nb;
    int order[8];

    repeat (3) step();
    #2;
    chk("reset_grant", grant, '0);
    chk("reset_busy", busy, '0);
    chk("reset_result", result, '0);
    step();
    rst_n = 1'b1;

    // single job: grant +1, trigger +2, finish 5 after trigger, done one later
    step();
    req = 4'b0001; eng_val = {OUT{16'h0010}}; eng_lat = 5; c_req = cyc;
    step(); #2;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_sel", layer_sel, 0);
    chk("t1_trig_early", lin_trigger, 1'b0);
    step(); #2;
    chk("t1_trig", lin_trigger, 1'b1);
    chk("t1_trig_lat", cyc - c_req, 2);
    c_trig = cyc;
    wait_done(20, "t1_done_wait");
    c_done = cyc; #2;
    chk("t1_done", done, 4'b0001);
    chk("t1_done_lat", c_done - c_trig, 6);
    chk("t1_result", result, {OUT{16'h0010}});
    req = '0;
    step(); #2;
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_grant_after", grant, '0);

    // all requesting: strict rotation from requester 0 after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'b1111; eng_lat = 3; eng_val = {OUT{16'h0BEE}};
    nd = 0; ntrig = 0;
    for (int k = 0; k < 200 && nd < 8; k++) begin
      step();
      if (lin_trigger) ntrig++;
      if (done != '0) begin
        order[nd] = oh_idx(done);
        nd++;
      end
    end
    req = '0;
    chk("t2_jobs", nd, 8);
    chk("t2_triggers", ntrig, 8);
    for (int i = 0; i < 8; i++) chk("t2_order", order[i], exp_ord[i]);

    // req dropped after grant: job still completes, next scan starts at 3
    step();
    req = 4'b0100; eng_val = {OUT{16'hA5A5}};
    step(); #2;
    chk("t3_grant", grant, 4'b0100);
    step();
    req = '0;
    wait_done(20, "t3_done_wait"); #2;
    chk("t3_done", done, 4'b0100);
    req = 4'b1111;
    wait_grant(10, "t3_grant_wait"); #2;
    chk("t3_next_grant", grant, 4'b1000);
    wait_done(20, "t3_done2_wait");
    req = '0;

    // spurious finish while idle is ignored
    step(); step();
    lin_finish = 1'b1; lin_out = {OUT{16'hFFFF}};
    step(); #2;
    chk("t4_result_kept", result, {OUT{16'hA5A5}});
    chk("t4_no_done", done, '0);
    chk("t4_idle", busy, 1'b0);

    // reset during RUN, then a fresh job for requester 1
    step();
    req = 4'b0001; eng_lat = 10;
    repeat (4) step();
    rst_n = 1'b0; #2;
    chk("t5_rst_grant", grant, '0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_result", result, '0);
    req = '0;
    step(); step();
    rst_n = 1'b1; req = 4'b0010; eng_lat = 3; eng_val = {OUT{16'h1234}};
    wait_grant(10, "t5_grant_wait"); #2;
    chk("t5_grant", grant, 4'b0010);
    chk("t5_sel", layer_sel, 1);
    wait_done(20, "t5_done_wait"); #2;
    chk("t5_done", done, 4'b0010);
    chk("t5_result", result, {OUT{16'h1234}});
    req = '0;

    // single requester held high is served back-to-back
    step();
    req = 4'b1000; nd = 0;
    for (int k = 0; k < 100 && nd < 3; k++) begin
      step();
      if (done != '0) begin
        chk("t6_done_owner", done, 4'b1000);
        nd++;
      end
    end
    req = '0;
    chk("t6_jobs", nd, 3);
    repeat (3) step();

    // randomized traffic, latencies, early drops and spurious finishes
    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    req = '0;
    nb = 1;
    for (int k = 0; k < 50 && nb != 0; k++) begin
      step();
      nb = int'(busy);
    end
    chk("drain_idle", nb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
